// File: rtl/instr_fetch.sv
// Instruction fetch front end: drives imem every cycle, tracks the 1-cycle read latency, queues {pc,instr} in 2 entries.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise misalign and stall issue instead of aligning down.
module instr_fetch #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_instr,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic                     misalign
`endif
);

  localparam logic [ADDRESS_WIDTH-1:0] STEP = ADDRESS_WIDTH'(4);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ~ADDRESS_WIDTH'(3);

  logic [ADDRESS_WIDTH-1:0] pc_q;
  logic [ADDRESS_WIDTH-1:0] inflight_pc_q;
  logic                     inflight_q;
  logic [ADDRESS_WIDTH-1:0] target;
  logic                     target_ok;
  logic                     blocked;
  logic                     pop;
  logic                     push;
  logic                     issue;
  logic [1:0]               count_q;
  logic [1:0]               wr_idx;
  logic [2:0]               occupancy;
  logic [ADDRESS_WIDTH-1:0] pc0_q;
  logic [ADDRESS_WIDTH-1:0] pc1_q;
  logic [DATA_WIDTH-1:0]    instr0_q;
  logic [DATA_WIDTH-1:0]    instr1_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign target    = redirect_pc;
  assign target_ok = (redirect_pc[1:0] == 2'b00);
  assign blocked   = misalign_q;
  assign misalign  = misalign_q;

  // Sticky until the next redirect decides alignment again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= ~target_ok;
    end
  end
`else
  assign target    = redirect_pc & ALIGN_MASK;
  assign target_ok = 1'b1;
  assign blocked   = 1'b0;
`endif

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid & out_ready;
  assign push      = inflight_q & ~redirect_valid;
  assign occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (occupancy < 3'd2) & ~blocked;
  assign wr_idx    = count_q - {1'b0, pop};
  assign out_pc    = pc0_q;
  assign out_instr = instr0_q;

  // Redirect target goes to memory in the same cycle to keep the penalty at 2.
  assign imem_addr = rst ? RESET_PC : (redirect_valid ? target : pc_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      inflight_q    <= target_ok;
      inflight_pc_q <= target;
      pc_q          <= target + STEP;
    end else if (issue) begin
      inflight_q    <= 1'b1;
      inflight_pc_q <= pc_q;
      pc_q          <= pc_q + STEP;
    end else begin
      inflight_q    <= 1'b0;
    end
  end

  // Entry 0 is always the head; a pop shifts entry 1 down before the push lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      pc0_q    <= '0;
      pc1_q    <= '0;
      instr0_q <= '0;
      instr1_q <= '0;
    end else if (redirect_valid) begin
      count_q <= 2'd0;
    end else begin
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
      if (pop) begin
        pc0_q    <= pc1_q;
        instr0_q <= instr1_q;
      end
      if (push && wr_idx == 2'd0) begin
        pc0_q    <= inflight_pc_q;
        instr0_q <= imem_instr;
      end
      if (push && wr_idx == 2'd1) begin
        pc1_q    <= inflight_pc_q;
        instr1_q <= imem_instr;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: the expected stream is the PC sequence restarted at each redirect target.
`timescale 1ns/1ps
module tb_instr_fetch;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam logic [AW-1:0] RPC = 32'h0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_instr = '0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic          misalign;
`endif

  int tests = 0;
  int fails = 0;
  int hs_count = 0;
  int hs10 = 0;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] next_pc;
  bit            blocked;

  always #5 clk = ~clk;

  instr_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(RPC)) dut (
    .clk(clk),
    .rst(rst),
    .imem_addr(imem_addr),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_instr(out_instr),
    .out_pc(out_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    .misalign(misalign)
`endif
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5a3c_0ff1;
  endfunction

  // Synchronous-read memory: word for the address sampled at this edge is visible next cycle.
  always @(posedge clk) imem_instr <= memf(imem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic topup();
    if (!blocked)
      while (exp_q.size() < 4) begin
        exp_q.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
  endtask

  task automatic model_reset();
    exp_q.delete();
    next_pc = RPC;
    blocked = 1'b0;
    topup();
  endtask

  // Advance one edge, then fold the redirect that was presented in the finished cycle into the model.
  task automatic tick();
    @(posedge clk);
    #1;
    if (redirect_valid) begin
      exp_q.delete();
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        blocked = 1'b1;
      end else begin
        blocked = 1'b0;
        next_pc = redirect_pc;
      end
`else
      next_pc = {redirect_pc[AW-1:2], 2'b00};
`endif
    end
    topup();
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [AW-1:0] pc;
      hs_count++;
      if (out_pc == 32'h10) hs10++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got pc %h expected no output", out_pc);
      end else begin
        pc = exp_q.pop_front();
        check("out_pc", out_pc, pc);
        check("out_instr", out_instr, memf(pc));
      end
    end
  end

  initial begin
    int found;
    int hs_before;
    logic [AW-1:0] r;

    #1 rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_instr", out_instr, 0);
    check("rst_imem_addr", imem_addr, RPC);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misalign", misalign, 0);
`endif
    model_reset();
    repeat (2) tick();

    // Reset release with decode always ready
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    check("valid_after_E1", out_valid, 0);
    tick();
    check("valid_after_E2", out_valid, 1);
    check("first_pc", out_pc, RPC);
    repeat (8) tick();

    // Asynchronous reset mid-cycle
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_pc", out_pc, 0);
    check("async_rst_instr", out_instr, 0);
    check("async_rst_imem_addr", imem_addr, RPC);
    model_reset();
    hs10 = 0;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    tick();
    check("restart_valid_E1", out_valid, 0);
    tick();
    check("restart_valid_E2", out_valid, 1);
    check("restart_pc", out_pc, RPC);

    // Backpressure: queue fills, next unissued address held
    repeat (5) begin
      tick();
      check("stall_imem_addr", imem_addr, 32'h8);
      check("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      check("no_gap_valid", out_valid, 1);
    end

    // Redirect in the same cycle as the pop of 0x10
    found = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && out_pc == 32'h10) begin
        found = 1;
        break;
      end
      tick();
    end
    check("found_pc10", found, 1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    tick();
    check("redir_valid", out_valid, 1);
    check("redir_pc", out_pc, 32'h40);
    check("pc10_once", hs10, 1);
    repeat (3) tick();

    // Redirect with the queue full
    out_ready = 1'b0;
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    check("full_flush_valid", out_valid, 0);
    tick();
    check("full_redir_valid", out_valid, 1);
    check("full_redir_pc", out_pc, 32'h40);
    out_ready = 1'b1;
    repeat (3) tick();

    // Misaligned redirect target
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_set", misalign, 1);
    repeat (3) begin
      tick();
      check("misalign_blocked_valid", out_valid, 0);
      check("misalign_held", misalign, 1);
    end
`else
    tick();
    check("align_down_pc", out_pc, 32'h40);
    check("align_down_valid", out_valid, 1);
`endif
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_clear", misalign, 0);
`endif
    tick();
    check("aligned_redir_pc", out_pc, 32'h80);
    check("aligned_redir_valid", out_valid, 1);

    // Randomized traffic, including targets near the top of the address space
    hs_before = hs_count;
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = (($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : 32'h0) | ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 3) == 0) r[1:0] = 2'($urandom_range(1, 3));
      redirect_pc = r;
      tick();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("random_progress", (hs_count - hs_before) > 40, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
